sha256_msg_sequencer: RTL and testbench

Front-end controller for the SHA256 compression core: accepts the message as a byte stream, performs SHA-256 padding (0x80, zero fill, 64-bit big-endian bit length) and sequences 512-bit blocks into the core as sixteen 32-bit words per block. It tells the core when a new message starts, which block is last, and holds further input until the core reports that each block is done. It sits between the byte-level stimulus/host interface and the core's word-level message-schedule input.

---
 rtl/sha256_pkg.sv | 22 ++
 rtl/sha256_block_buffer.sv | 40 ++++
 rtl/sha256_msg_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_sha256_msg_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared definitions for the SHA-256 message front end.
//   state_t      sequencer FSM states
//   BLOCK_WORDS  32-bit words per 512-bit block
//   PAD_BYTE     first padding byte appended after the message
//   LEN_POS      byte position where the 64-bit bit length starts
package sha256_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PAD_ZERO,
    S_PAD_LEN,
    S_SEND,
    S_WAIT_CORE,
    S_DONE
  } state_t;

  localparam int         BLOCK_WORDS = 16;
  localparam logic [7:0] PAD_BYTE    = 8'h80;
  localparam logic [5:0] LEN_POS     = 6'd56;

endpackage

// File: rtl/sha256_block_buffer.sv
// sha256_block_buffer: 16 x 32-bit block store, big-endian byte packing.
//   clock      rising-edge clock
//   byte_we    write byte_data at byte_pos (byte 0 = MSB of word 0)
//   byte_pos   byte position 0..63 inside the block
//   byte_data  byte to write
//   len_we     write len_bits into words 14 (high half) and 15 (low half)
//   len_bits   64-bit message length in bits
//   rd_index   word read index
//   rd_word    combinational read data
module sha256_block_buffer
  import sha256_pkg::*;
(
  input  logic        clock,
  input  logic        byte_we,
  input  logic [5:0]  byte_pos,
  input  logic [7:0]  byte_data,
  input  logic        len_we,
  input  logic [63:0] len_bits,
  input  logic [3:0]  rd_index,
  output logic [31:0] rd_word
);

  logic [31:0] mem [BLOCK_WORDS];

  // NOTE: the storage array has no reset; every byte of a block is written
  // (message, 0x80, zero fill, length) before the block is ever read.
  always_ff @(posedge clock) begin
    if (byte_we) begin
      // Lane 0 of a word is its most significant byte.
      mem[byte_pos[5:2]][{~byte_pos[1:0], 3'b000} +: 8] <= byte_data;
    end
    if (len_we) begin
      mem[4'd14] <= len_bits[63:32];
      mem[4'd15] <= len_bits[31:0];
    end
  end

  assign rd_word = mem[rd_index];

endmodule

// File: rtl/sha256_msg_sequencer.sv
// sha256_msg_sequencer: byte-stream to SHA-256 block sequencer with padding.
//   clock            rising-edge clock
//   reset            asynchronous, active-low
//   load_enable      input_data valid (taken when in_ready)
//   input_data       message byte
//   input_complete   end-of-message marker (taken when in_ready)
//   in_ready         sequencer accepts a byte / end marker this cycle
//   core_start       one-cycle pulse: core reloads H0..H7
//   word_valid       word_data valid toward the core
//   word_data        big-endian message word
//   word_index       index 0..15 of word_data in the block
//   block_last       current block is the final block of the message
//   word_ready       core accepts the word this cycle
//   core_block_done  core finished compressing the block
//   msg_done         one-cycle pulse after the final block completes
//   length_error     sticky byte-counter overflow flag
module sha256_msg_sequencer
  import sha256_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_enable,
  input  logic [7:0]  input_data,
  input  logic        input_complete,
  output logic        in_ready,
  output logic        core_start,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [3:0]  word_index,
  output logic        block_last,
  input  logic        word_ready,
  input  logic        core_block_done,
  output logic        msg_done,
  output logic        length_error
);

  state_t           state, resume;
  logic [5:0]       pos;
  logic [LEN_W-1:0] len;

  logic        buf_we;
  logic [5:0]  buf_pos;
  logic [7:0]  buf_byte;
  logic [3:0]  rd_index;
  logic [31:0] rd_word;
  logic        launch, launch_last;
  state_t      launch_resume;

  assign in_ready = (state == S_IDLE) || (state == S_FILL);

  // While streaming, prefetch the word after the one being handed over;
  // otherwise word 0 is what the next block launch loads.
  assign rd_index = (state == S_SEND) ? word_index + 4'd1 : 4'd0;

  sha256_block_buffer u_buffer (
    .clock     (clock),
    .byte_we   (buf_we),
    .byte_pos  (buf_pos),
    .byte_data (buf_byte),
    .len_we    (state == S_PAD_LEN),
    .len_bits  (64'(len) << 3),
    .rd_index  (rd_index),
    .rd_word   (rd_word)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    buf_we        = 1'b0;
    buf_pos       = pos;
    buf_byte      = 8'h00;
    launch        = 1'b0;
    launch_last   = 1'b0;
    launch_resume = S_FILL;
    unique case (state)
      S_IDLE: begin
        buf_pos = 6'd0;
        if (load_enable) begin
          buf_we   = 1'b1;
          buf_byte = input_data;
        end else if (input_complete) begin
          buf_we   = 1'b1;
          buf_byte = PAD_BYTE;
        end
      end
      S_FILL: begin
        if (load_enable) begin
          buf_we   = 1'b1;
          buf_byte = input_data;
          launch   = (pos == 6'd63);
        end else if (input_complete) begin
          // 0x80 in the last byte: this block goes out, padding continues
          // in a fresh block.
          buf_we        = 1'b1;
          buf_byte      = PAD_BYTE;
          launch        = (pos == 6'd63);
          launch_resume = S_PAD_ZERO;
        end
      end
      S_PAD_ZERO: begin
        if (pos != LEN_POS) begin
          buf_we        = 1'b1;
          launch        = (pos == 6'd63);
          launch_resume = S_PAD_ZERO;
        end
      end
      S_PAD_LEN: begin
        launch        = 1'b1;
        launch_last   = 1'b1;
        launch_resume = S_DONE;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and the later launch override
  // simply wins over the per-state next-state choice.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      resume       <= S_IDLE;
      pos          <= 6'd0;
      len          <= '0;
      core_start   <= 1'b0;
      word_valid   <= 1'b0;
      word_data    <= 32'h0;
      word_index   <= 4'd0;
      block_last   <= 1'b0;
      msg_done     <= 1'b0;
      length_error <= 1'b0;
    end else begin
      core_start <= 1'b0;
      msg_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_enable || input_complete) begin
            core_start   <= 1'b1;
            length_error <= 1'b0;
            pos          <= 6'd1;
            len          <= load_enable ? LEN_W'(1) : '0;
            state        <= load_enable ? S_FILL : S_PAD_ZERO;
          end
        end
        S_FILL: begin
          if (load_enable) begin
            pos <= pos + 6'd1;
            if (len == '1) length_error <= 1'b1;
            else           len          <= len + LEN_W'(1);
          end else if (input_complete) begin
            pos   <= pos + 6'd1;
            state <= S_PAD_ZERO;
          end
        end
        S_PAD_ZERO: begin
          if (pos == LEN_POS) state <= S_PAD_LEN;
          else                pos   <= pos + 6'd1;
        end
        S_SEND: begin
          if (word_ready) begin
            if (word_index == 4'd15) begin
              word_valid <= 1'b0;
              block_last <= 1'b0;
              state      <= S_WAIT_CORE;
            end else begin
              word_index <= word_index + 4'd1;
              word_data  <= rd_word;
            end
          end
        end
        S_WAIT_CORE: begin
          if (core_block_done) begin
            state    <= resume;
            msg_done <= (resume == S_DONE);
          end
        end
        S_DONE: begin
          pos   <= 6'd0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (launch) begin
        state      <= S_SEND;
        resume     <= launch_resume;
        word_valid <= 1'b1;
        word_index <= 4'd0;
        word_data  <= rd_word;
        block_last <= launch_last;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// tb_sha256_msg_sequencer: directed bench for sha256_msg_sequencer.
// Expected words come from a byte-level SHA-256 padding model and are queued
// per message; the block handshake and a simple core model run alongside.
module tb_sha256_msg_sequencer;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [31:0] data;
    logic [3:0]  index;
    logic        last;
  } exp_word_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_enable = 1'b0;
  logic [7:0]  input_data = 8'h00;
  logic        input_complete = 1'b0;
  logic        in_ready;
  logic        core_start;
  logic        word_valid;
  logic [31:0] word_data;
  logic [3:0]  word_index;
  logic        block_last;
  logic        word_ready = 1'b0;
  logic        core_block_done = 1'b0;
  logic        msg_done;
  logic        length_error;

  exp_word_t sb[$];
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  sha256_msg_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .load_enable     (load_enable),
    .input_data      (input_data),
    .input_complete  (input_complete),
    .in_ready        (in_ready),
    .core_start      (core_start),
    .word_valid      (word_valid),
    .word_data       (word_data),
    .word_index      (word_index),
    .block_last      (block_last),
    .word_ready      (word_ready),
    .core_block_done (core_block_done),
    .msg_done        (msg_done),
    .length_error    (length_error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Padding model: message, 0x80, zeros to 56 mod 64, 64-bit bit length.
  task automatic push_expected(input bytes_t msg);
    bytes_t      p;
    logic [63:0] bits;
    exp_word_t   e;
    int          nblk;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int w = 0; w < 16; w++) begin
        int base;
        base    = b * 64 + w * 4;
        e.data  = {p[base], p[base+1], p[base+2], p[base+3]};
        e.index = 4'(w);
        e.last  = (b == nblk - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},     in_ready,     1);
    check({tag, "_core_start"},   core_start,   0);
    check({tag, "_word_valid"},   word_valid,   0);
    check({tag, "_word_data"},    word_data,    0);
    check({tag, "_word_index"},   word_index,   0);
    check({tag, "_block_last"},   block_last,   0);
    check({tag, "_msg_done"},     msg_done,     0);
    check({tag, "_length_error"}, length_error, 0);
  endtask

  // Feeds one message, consumes its words against the scoreboard and plays
  // the core. abort_after > 0 returns after that many accepted words.
  task automatic run_message(input string name, input bytes_t msg, input bit random_ready,
                             input bit drop_junk, input bit overlap, input int abort_after);
    int          idx = 0;
    int          cycles = 0;
    int          accepted = 0;
    int          wait_cnt = -1;
    int          starts = 0;
    bit          end_sent = 0;
    bit          started = 0;
    bit          expect_start = 0;
    bit          stalled = 0;
    bit          done_seen = 0;
    bit          pending_last = 0;
    bit          done_final_driven = 0;
    logic [31:0] st_data = 0;
    logic [3:0]  st_idx = 0;
    exp_word_t   e;

    load_enable = 0; input_complete = 0; core_block_done = 0; word_ready = 0;
    while (cycles < 4000) begin
      @(negedge clock);
      cycles++;
      // observe
      if (core_start) starts++;
      if (expect_start) check({name, "_core_start"}, core_start, 1);
      expect_start = 0;
      if (done_final_driven || msg_done) begin
        check({name, "_msg_done"}, msg_done, done_final_driven);
        done_seen = 1;
      end
      done_final_driven = 0;
      if (stalled) begin
        check({name, "_stall_valid"}, word_valid, 1);
        check({name, "_stall_data"},  word_data,  st_data);
        check({name, "_stall_index"}, word_index, st_idx);
      end
      stalled = 0;
      if (abort_after > 0 && accepted >= abort_after) return;
      if (done_seen) break;

      // core model
      core_block_done = 0;
      if (wait_cnt > 0) begin
        check({name, "_in_ready_wait"}, in_ready, 0);
        wait_cnt--;
        if (wait_cnt == 0) begin
          core_block_done   = 1;
          done_final_driven = pending_last;
          wait_cnt          = -1;
        end
      end

      // word consumer
      word_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (word_valid) begin
        check({name, "_in_ready_send"}, in_ready, 0);
        if (word_ready) begin
          if (sb.size() == 0) begin
            check({name, "_unexpected_word"}, word_data, 64'hdead_0000_0000);
          end else begin
            e = sb.pop_front();
            check({name, "_word_data"},  word_data,  e.data);
            check({name, "_word_index"}, word_index, e.index);
            check({name, "_block_last"}, block_last, e.last);
            accepted++;
            if (e.index == 4'd15) begin
              wait_cnt     = 3;
              pending_last = e.last;
            end
          end
        end else begin
          stalled = 1;
          st_data = word_data;
          st_idx  = word_index;
        end
      end

      // byte source
      load_enable    = 0;
      input_complete = 0;
      if (in_ready) begin
        if (!started) expect_start = 1;
        started = 1;
        if (idx < msg.size()) begin
          load_enable = 1;
          input_data  = msg[idx];
          if (overlap && idx == msg.size() - 1) input_complete = 1;
          idx++;
        end else if (!end_sent) begin
          input_complete = 1;
          end_sent       = 1;
        end
      end else if (drop_junk && !end_sent) begin
        load_enable    = 1;
        input_data     = 8'hA5;
        input_complete = 1;
      end
    end

    load_enable = 0; input_complete = 0; core_block_done = 0; word_ready = 0;
    check({name, "_finished"}, done_seen, 1);
    check({name, "_sb_empty"}, sb.size(), 0);
    check({name, "_start_count"}, starts, 1);
    check({name, "_length_error"}, length_error, 0);
    @(negedge clock);
    check({name, "_msg_done_single"}, msg_done, 0);
    check({name, "_idle_ready"}, in_ready, 1);
  endtask

  initial begin
    bytes_t m;
    string  s;

    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1;
    @(negedge clock);

    s = "goirish\n";
    m = {};
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    push_expected(m);
    run_message("goirish", m, 0, 0, 0, 0);

    m = {};
    push_expected(m);
    run_message("empty", m, 0, 0, 0, 0);

    m = {};
    for (int i = 0; i < 55; i++) m.push_back(8'h00);
    push_expected(m);
    run_message("zeros55", m, 0, 0, 0, 0);

    m = {};
    for (int i = 0; i < 56; i++) m.push_back(8'h00);
    push_expected(m);
    run_message("zeros56", m, 0, 0, 0, 0);

    m = {};
    for (int i = 0; i < 70; i++) m.push_back(8'($urandom_range(0, 255)));
    push_expected(m);
    run_message("stall_drop", m, 1, 1, 1, 0);

    m = {};
    for (int i = 0; i < 63; i++) m.push_back(8'(i + 1));
    push_expected(m);
    run_message("pad_wrap63", m, 1, 0, 0, 0);

    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'h11 + 8'(i));
    push_expected(m);
    run_message("abort", m, 0, 0, 0, 5);
    reset = 0;
    sb.delete();
    load_enable = 0; input_complete = 0; core_block_done = 0; word_ready = 0;
    @(negedge clock);
    check_reset_outputs("abort_reset");
    reset = 1;
    @(negedge clock);

    s = "abc";
    m = {};
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    push_expected(m);
    run_message("abc", m, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
